load_store_unit: RTL

// - CPU-side load/store front end placed directly upstream of MemoryBlock. It drives that

---
 rtl/load_store_unit.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store front end for MemoryBlock.
// Optional misalignment trap: define MISALIGN_TRAP_EN.
// Ports: clk, reset (async, active-high); request handshake
//   req_valid/req_ready with req_write/size/signed/addr/wdata;
//   response resp_valid/resp_data/resp_fault (no backpressure);
//   memory side mem_address/mem_write_enable/mem_write_value/mem_read_value.
module load_store_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] mem_address,
    output logic [1:0]        mem_write_enable,
    output logic [31:0]       mem_write_value,
    input  logic [31:0]       mem_read_value
);

    typedef enum logic [2:0] {IDLE, WRITE, READ0, READ1, RESP} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [31:0]       wdata_q;
    logic [1:0]        beat_q;
    logic [1:0]        last_q;
    logic [31:0]       lo_q;
    logic [1:0]        next_beat;

    function automatic logic is_misaligned(input logic [1:0] sz,
                                           input logic [1:0] lo);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return lo[0];
            default: return lo != 2'b00;
        endcase
    endfunction

    // Access crosses into the next word: needs a second read.
    function automatic logic is_split(input logic [1:0] sz,
                                      input logic [1:0] lo);
        case (sz)
            2'b00:   return 1'b0;
            2'b01:   return lo == 2'b11;
            default: return lo != 2'b00;
        endcase
    endfunction

    // w holds {next word, first word}; shift down to the addressed byte.
    function automatic logic [31:0] extract(input logic [63:0] w,
                                            input logic [1:0]  lo,
                                            input logic [1:0]  sz,
                                            input logic        sg);
        logic [31:0] s;
        s = 32'(w >> {lo, 3'b000});
        case (sz)
            2'b00:   return {{24{sg & s[7]}}, s[7:0]};
            2'b01:   return {{16{sg & s[15]}}, s[15:0]};
            default: return s;
        endcase
    endfunction

    assign req_ready = (state == IDLE);
    assign next_beat = beat_q + 2'd1;

`ifdef MISALIGN_TRAP_EN
    logic fault_q;
    assign resp_fault = fault_q;
`else
    assign resp_fault = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            addr_q           <= '0;
            size_q           <= 2'b00;
            sign_q           <= 1'b0;
            wdata_q          <= '0;
            beat_q           <= 2'd0;
            last_q           <= 2'd0;
            lo_q             <= '0;
            resp_valid       <= 1'b0;
            resp_data        <= '0;
            mem_address      <= '0;
            mem_write_enable <= 2'b00;
            mem_write_value  <= '0;
`ifdef MISALIGN_TRAP_EN
            fault_q          <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        size_q  <= req_size;
                        sign_q  <= req_signed;
                        wdata_q <= req_wdata;
                        beat_q  <= 2'd0;
`ifdef MISALIGN_TRAP_EN
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_data  <= '0;
                            fault_q    <= 1'b1;
                        end else
`endif
                        if (req_write) begin
                            state       <= WRITE;
                            mem_address <= req_addr;
                            if (is_misaligned(req_size, req_addr[1:0])) begin
                                // Split into single-byte beats.
                                mem_write_enable <= 2'b01;
                                mem_write_value  <= {24'h0, req_wdata[7:0]};
                                last_q <= (req_size == 2'b01) ? 2'd1 : 2'd3;
                            end else begin
                                case (req_size)
                                    2'b00:   mem_write_enable <= 2'b01;
                                    2'b01:   mem_write_enable <= 2'b10;
                                    default: mem_write_enable <= 2'b11;
                                endcase
                                mem_write_value <= req_wdata;
                                last_q          <= 2'd0;
                            end
                        end else begin
                            state       <= READ0;
                            mem_address <= {req_addr[ADDR_W-1:2], 2'b00};
                        end
                    end
                end
                WRITE: begin
                    if (beat_q == last_q) begin
                        state            <= RESP;
                        mem_write_enable <= 2'b00;
                        mem_write_value  <= '0;
                        resp_valid       <= 1'b1;
                        resp_data        <= '0;
                    end else begin
                        beat_q          <= next_beat;
                        mem_address     <= mem_address + ADDR_W'(1);
                        mem_write_value <= {24'h0,
                                            wdata_q[{next_beat, 3'b000} +: 8]};
                    end
                end
                READ0: begin
                    lo_q <= mem_read_value;
                    if (is_split(size_q, addr_q[1:0])) begin
                        state       <= READ1;
                        mem_address <= mem_address + ADDR_W'(4);
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_data  <= extract({32'h0, mem_read_value},
                                              addr_q[1:0], size_q, sign_q);
                    end
                end
                READ1: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_data  <= extract({mem_read_value, lo_q},
                                          addr_q[1:0], size_q, sign_q);
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_data  <= '0;
`ifdef MISALIGN_TRAP_EN
                    fault_q    <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
